// File: rtl/msg_checker.sv
// msg_checker
//   Reads the decrypted message back from d_memory one byte at a time and
//   checks that every byte is plaintext: lowercase 'a'..'z' or space. The
//   first illegal byte ends the check early. The verdict goes to the
//   key-search controller, which uses it to decide whether to advance
//   secret_key.
//
// Ports
//   clk        in   system clock (CLK_50M at top level)
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a check; only looked at in IDLE
//   rd_addr    out  d_memory read address (held in IDLE/DONE)
//   rd_q       in   d_memory read data, valid RD_LAT edges after rd_addr moves
//   busy       out  high from start acceptance until the verdict edge
//   done       out  one-cycle pulse on the verdict edge
//   valid      out  1 = every byte legal; held until the next accepted start
//   fail_index out  address of the first illegal byte (0 when valid)
//   bad_char   out  value of the first illegal byte (0 when valid)

module msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_q,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] fail_index,
    output logic [7:0]        bad_char
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              legal;
    logic              last;
    logic              wait_over;

    // The byte index doubles as the read address, so rd_addr naturally
    // holds its last value once the FSM leaves the byte loop.
    assign rd_addr   = idx;
    assign legal     = (rd_q == 8'h20) || ((rd_q >= 8'h61) && (rd_q <= 8'h7A));
    assign last      = (idx == ADDR_W'(MSG_LEN - 1));
    // WAIT lasts RD_LAT-1 cycles; with RD_LAT==1 it is never entered.
    assign wait_over = (wait_cnt == CNT_W'(RD_LAT - 2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ADDR;
            ADDR:  state_nxt = (RD_LAT > 1) ? WAIT : CHECK;
            WAIT:  if (wait_over) state_nxt = CHECK;
            CHECK: state_nxt = (!legal || last) ? DONE : ADDR;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            fail_index <= '0;
            bad_char   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        busy       <= 1'b1;
                        valid      <= 1'b0;
                        fail_index <= '0;
                        bad_char   <= '0;
                    end
                end
                ADDR: wait_cnt <= '0;
                WAIT: wait_cnt <= wait_cnt + CNT_W'(1);
                CHECK: begin
                    if (!legal) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        fail_index <= idx;
                        bad_char   <= rd_q;
                    end else if (last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_checker.sv
// Directed bench for msg_checker: a table of message patterns with
// hand-computed verdicts and latencies, plus hand-written sequences for
// start re-pulse, held start and mid-check reset.

module tb_msg_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] rd_addr;
    logic [7:0] rd_q;
    logic       busy, done, valid;
    logic [4:0] fail_index;
    logic [7:0] bad_char;

    int nvec = 0;
    int nfail = 0;

    logic [7:0] mem [32];
    logic [7:0] q1;

    msg_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr),
        .rd_q(rd_q), .busy(busy), .done(done), .valid(valid),
        .fail_index(fail_index), .bad_char(bad_char)
    );

    always #5 clk = ~clk;

    // Two-stage registered read: data for an address is on rd_q two edges
    // after the address changes.
    always @(posedge clk) begin
        q1   <= mem[rd_addr];
        rd_q <= q1;
    end

    typedef struct {
        logic [7:0] fill;
        int         pos;
        logic [7:0] val;
        logic       ev;
        int         efi;
        logic [7:0] ebc;
        int         ecyc;
        int         emax;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] fill, input int pos, input logic [7:0] val);
        for (int i = 0; i < 32; i++) mem[i] = fill;
        mem[pos] = val;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int n, prev, maxa, step_err, busy_err;
        load(v.fill, v.pos, v.val);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d busy@E0", id), int'(busy), 1);
        chk($sformatf("v%0d clear@E0", id), int'({valid, fail_index, bad_char, rd_addr}), 0);
        @(negedge clk) start = 1'b0;
        n = 0; prev = 0; maxa = 0; step_err = 0; busy_err = 0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (int'(rd_addr) != prev && int'(rd_addr) != prev + 1) step_err++;
            prev = int'(rd_addr);
            if (int'(rd_addr) > maxa) maxa = int'(rd_addr);
            if (done) break;
            if (!busy) busy_err++;
        end
        chk($sformatf("v%0d done_cycle", id), n, v.ecyc);
        chk($sformatf("v%0d valid", id), int'(valid), int'(v.ev));
        chk($sformatf("v%0d fail_index", id), int'(fail_index), v.efi);
        chk($sformatf("v%0d bad_char", id), int'(bad_char), int'(v.ebc));
        chk($sformatf("v%0d busy@done", id), int'(busy), 0);
        chk($sformatf("v%0d max_addr", id), maxa, v.emax);
        chk($sformatf("v%0d addr_step", id), step_err, 0);
        chk($sformatf("v%0d busy_gap", id), busy_err, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d done_pulse", id), int'(done), 0);
    endtask

    initial begin
        int n, ndone, first, second;

        //         fill   pos val    ev   efi ebc    ecyc emax
        tbl[0] = '{8'h61, 0,  8'h61, 1'b1, 0, 8'h00, 96, 31};
        tbl[1] = '{8'h20, 5,  8'h41, 1'b0, 5, 8'h41, 18, 5};
        tbl[2] = '{8'h61, 0,  8'h20, 1'b1, 0, 8'h00, 96, 31};
        tbl[3] = '{8'h20, 0,  8'h61, 1'b1, 0, 8'h00, 96, 31};
        tbl[4] = '{8'h20, 0,  8'h7A, 1'b1, 0, 8'h00, 96, 31};
        tbl[5] = '{8'h61, 0,  8'h1F, 1'b0, 0, 8'h1F, 3,  0};
        tbl[6] = '{8'h61, 0,  8'h60, 1'b0, 0, 8'h60, 3,  0};
        tbl[7] = '{8'h61, 0,  8'h7B, 1'b0, 0, 8'h7B, 3,  0};
        tbl[8] = '{8'h61, 0,  8'hE1, 1'b0, 0, 8'hE1, 3,  0};
        tbl[9] = '{8'h7A, 31, 8'h00, 1'b0, 31, 8'h00, 96, 31};

        load(8'h61, 0, 8'h61);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'({busy, done, valid, fail_index, bad_char, rd_addr}), 0);
        @(negedge clk) reset_n = 1'b1;

        // start re-pulsed mid-check is ignored
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) start = 1'b0;
        n = 0; ndone = 0; first = -1;
        while (n < 110) begin
            if (n == 9) begin
                @(negedge clk) start = 1'b1;
            end
            if (n == 10) begin
                @(negedge clk) start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        chk("repulse_ndone", ndone, 1);
        chk("repulse_cycle", first, 96);
        chk("repulse_valid", int'(valid), 1);

        // table vectors (first one also checks that start clears valid=1)
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // start held high: one check per return to IDLE
        load(8'h61, 0, 8'h61);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        n = 0; ndone = 0; first = -1; second = -1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        @(negedge clk) start = 1'b0;
        chk("held_ndone", ndone, 2);
        chk("held_first", first, 96);
        chk("held_second", second, 194);
        n = 0;
        while (n < 200 && !done) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_drain_timeout", int'(n < 200), 1);
        @(posedge clk); #1;

        // asynchronous reset mid-check
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) start = 1'b0;
        repeat (39) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({busy, done, valid, fail_index, bad_char, rd_addr}), 0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("reset_hold_quiet", ndone, 0);
        @(negedge clk) reset_n = 1'b1;
        run_vec(tbl[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
